// File: rtl/ray_pixel_scheduler_pkg.sv
// Shared types for the pixel scheduler: FSM state encoding and integer-to-fixed-point conversion.
// Latency: none (types and a pure function only); backpressure: not applicable.
package ray_pixel_scheduler_pkg;

   typedef enum logic [1:0] {
      SCHED_IDLE  = 2'd0,
      SCHED_ISSUE = 2'd1,
      SCHED_DRAIN = 2'd2,
      SCHED_DONE  = 2'd3
   } sched_state_t;

   // Caller truncates to its fixed-point width; the parameter constraint rules out overflow.
   function automatic logic [63:0] fp_from_int(input logic [31:0] count, input int unsigned frac);
      return {32'd0, count} << frac;
   endfunction

endpackage

// File: rtl/ray_pixel_scheduler_raster_counter.sv
// Row-major h/v raster counter with synchronous clear, advance enable and a combinational last-pixel flag.
// Latency: new position visible the cycle after advance_in; backpressure: holds position while advance_in is low.
module raster_counter #(
   parameter int DISPLAY_WIDTH  = 640,
   parameter int DISPLAY_HEIGHT = 480,
   parameter int H_BITS         = 10,
   parameter int V_BITS         = 10
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              clear_in,
   input  logic              advance_in,
   output logic [H_BITS-1:0] hcount_out,
   output logic [V_BITS-1:0] vcount_out,
   output logic              last_out
);

   logic last_col;

   assign last_col = (hcount_out == H_BITS'(DISPLAY_WIDTH - 1));
   assign last_out = last_col && (vcount_out == V_BITS'(DISPLAY_HEIGHT - 1));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hcount_out <= '0;
         vcount_out <= '0;
      end else if (clear_in) begin
         hcount_out <= '0;
         vcount_out <= '0;
      end else if (advance_in) begin
         if (last_col) begin
            hcount_out <= '0;
            vcount_out <= last_out ? '0 : vcount_out + V_BITS'(1);
         end else begin
            hcount_out <= hcount_out + H_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/ray_pixel_scheduler.sv
// Frame sequencer: issues raster pixels row-major over valid/ready, credit-limited to MAX_INFLIGHT rays in flight.
// Latency: first gen_valid_out 1 cycle after start_in; gen_ready_in low holds the pixel. SCHED_PERF_CNT_EN adds stall_cycles_out.
module ray_pixel_scheduler
   import ray_pixel_scheduler_pkg::*;
#(
   parameter int DISPLAY_WIDTH  = 640,
   parameter int DISPLAY_HEIGHT = 480,
   parameter int H_BITS         = 10,
   parameter int V_BITS         = 10,
   parameter int FP_BITS        = 32,
   parameter int FP_FRAC        = 16,
   parameter int MAX_INFLIGHT   = 8,
   parameter int CRED_BITS      = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   start_in,
   input  logic [3*FP_BITS-1:0]   cam_forward_in,
   output logic                   gen_valid_out,
   input  logic                   gen_ready_in,
   output logic [H_BITS-1:0]      hcount_out,
   output logic [V_BITS-1:0]      vcount_out,
   output logic [FP_BITS-1:0]     hcount_fp_out,
   output logic [FP_BITS-1:0]     vcount_fp_out,
   output logic [3*FP_BITS-1:0]   cam_forward_out,
   input  logic                   ret_in,
   output logic                   busy_out,
   output logic                   frame_done_out,
   output logic                   err_out
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [31:0]            stall_cycles_out
`endif
);

   localparam logic [CRED_BITS-1:0] MAX_CRED = CRED_BITS'(MAX_INFLIGHT);

   sched_state_t         state, state_nxt;
   logic [CRED_BITS-1:0] inflight;
   logic                 valid_hold, credit_ok, xfer, ret_ok, last_pix;
   logic                 raster_clr, cam_load;

   // valid_hold keeps an offered pixel up even if the credit count changes before the transfer
   assign credit_ok     = (inflight < MAX_CRED);
   assign gen_valid_out = (state == SCHED_ISSUE) && (valid_hold || credit_ok);
   assign xfer          = gen_valid_out && gen_ready_in;
   assign ret_ok        = ret_in && (inflight != '0);

   raster_counter #(
      .DISPLAY_WIDTH (DISPLAY_WIDTH),
      .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
      .H_BITS        (H_BITS),
      .V_BITS        (V_BITS)
   ) u_raster (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clear_in  (raster_clr),
      .advance_in(xfer),
      .hcount_out(hcount_out),
      .vcount_out(vcount_out),
      .last_out  (last_pix)
   );

   assign hcount_fp_out   = FP_BITS'(fp_from_int(32'(hcount_out), FP_FRAC));
   assign vcount_fp_out   = FP_BITS'(fp_from_int(32'(vcount_out), FP_FRAC));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= SCHED_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      raster_clr     = 1'b0;
      cam_load       = 1'b0;
      busy_out       = (state != SCHED_IDLE);
      frame_done_out = (state == SCHED_DONE);
      case (state)
         SCHED_IDLE: begin
            if (start_in) begin
               state_nxt  = SCHED_ISSUE;
               raster_clr = 1'b1;
               cam_load   = 1'b1;
            end
         end
         SCHED_ISSUE: if (xfer && last_pix) state_nxt = SCHED_DRAIN;
         // leave as soon as the last outstanding ray retires, not a cycle later
         SCHED_DRAIN: if ((inflight == '0) || ((inflight == CRED_BITS'(1)) && ret_in)) state_nxt = SCHED_DONE;
         SCHED_DONE:  state_nxt = SCHED_IDLE;
         default:     state_nxt = SCHED_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         inflight        <= '0;
         valid_hold      <= 1'b0;
         err_out         <= 1'b0;
         cam_forward_out <= '0;
      end else begin
         valid_hold <= gen_valid_out && !gen_ready_in;
         if (ret_in && (inflight == '0)) err_out <= 1'b1;
         if (xfer && !ret_ok)      inflight <= inflight + CRED_BITS'(1);
         else if (!xfer && ret_ok) inflight <= inflight - CRED_BITS'(1);
         if (cam_load) cam_forward_out <= cam_forward_in;
      end
   end

`ifdef SCHED_PERF_CNT_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         stall_cycles_out <= '0;
      else if (cam_load)
         stall_cycles_out <= '0;
      else if ((state == SCHED_ISSUE) && !xfer && (stall_cycles_out != '1))
         stall_cycles_out <= stall_cycles_out + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
// Bench for ray_pixel_scheduler on a 4x2 raster: instance a has 8 credits, instance b has 2.
module tb_ray_pixel_scheduler;

   localparam logic [95:0] CAM1 = 96'h0001_0000_0002_0000_0003_0000;
   localparam logic [95:0] CAM2 = 96'hdead_beef_cafe_f00d_1234_5678;
   localparam logic [95:0] CAM3 = 96'h0000_8000_ffff_0000_0000_4000;
   localparam logic [95:0] CAM4 = 96'h1111_2222_3333_4444_5555_6666;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        a_start, a_valid, a_ready, a_ret, a_busy, a_done, a_err;
   logic [95:0] a_cam_i, a_cam_o;
   logic [9:0]  a_h, a_v;
   logic [31:0] a_hfp, a_vfp;
   logic        b_start, b_valid, b_ready, b_ret, b_busy, b_done, b_err;
   logic [95:0] b_cam_i, b_cam_o;
   logic [9:0]  b_h, b_v;
   logic [31:0] b_hfp, b_vfp;
`ifdef SCHED_PERF_CNT_EN
   logic [31:0] a_stall, b_stall;
`endif

   int total = 0;
   int bad   = 0;
   logic [19:0] exp_a[$];
   logic [19:0] exp_b[$];

   ray_pixel_scheduler #(.DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2), .MAX_INFLIGHT(8)) u_a (
      .clk_in(clk), .rst_in(rst), .start_in(a_start), .cam_forward_in(a_cam_i),
      .gen_valid_out(a_valid), .gen_ready_in(a_ready), .hcount_out(a_h), .vcount_out(a_v),
      .hcount_fp_out(a_hfp), .vcount_fp_out(a_vfp), .cam_forward_out(a_cam_o), .ret_in(a_ret),
      .busy_out(a_busy), .frame_done_out(a_done), .err_out(a_err)
`ifdef SCHED_PERF_CNT_EN
      , .stall_cycles_out(a_stall)
`endif
   );

   ray_pixel_scheduler #(.DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2), .MAX_INFLIGHT(2)) u_b (
      .clk_in(clk), .rst_in(rst), .start_in(b_start), .cam_forward_in(b_cam_i),
      .gen_valid_out(b_valid), .gen_ready_in(b_ready), .hcount_out(b_h), .vcount_out(b_v),
      .hcount_fp_out(b_hfp), .vcount_fp_out(b_vfp), .cam_forward_out(b_cam_o), .ret_in(b_ret),
      .busy_out(b_busy), .frame_done_out(b_done), .err_out(b_err)
`ifdef SCHED_PERF_CNT_EN
      , .stall_cycles_out(b_stall)
`endif
   );

   task automatic load_exp(output logic [19:0] q[$]);
      q.delete();
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++)
            q.push_back({10'(y), 10'(x)});
   endtask

   task automatic start_a(input logic [95:0] cam);
      load_exp(exp_a);
      a_cam_i = cam;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   // Runs instance a with ready high, retiring each ray dly cycles after its transfer.
   task automatic run_a(input string tag, input int dly, input int budget,
                        output int n_x, output int first_x, output int last_x,
                        output int done_cnt, output int done_at, output int last_ret);
      int ret_at[$];
      logic [19:0] e;
      n_x = 0; first_x = -1; last_x = -1; done_cnt = 0; done_at = -1; last_ret = -1;
      for (int c = 0; c < budget; c++) begin
         a_ready = 1'b1;
         a_ret   = 1'b0;
         if (ret_at.size() > 0 && ret_at[0] == c) begin
            a_ret = 1'b1;
            void'(ret_at.pop_front());
            last_ret = c;
         end
         if (a_done) begin done_cnt++; done_at = c; end
         if (a_valid) begin
            n_x++;
            if (first_x < 0) first_x = c;
            last_x = c;
            ret_at.push_back(c + dly);
            total++;
            if (exp_a.size() == 0) begin
               bad++;
               $display("FAIL %s_extra_pixel got (%0d,%0d) want none", tag, a_h, a_v);
            end else begin
               e = exp_a.pop_front();
               if ({a_h, a_v, a_hfp, a_vfp} !== {e[9:0], e[19:10], 6'd0, e[9:0], 16'd0, 6'd0, e[19:10], 16'd0}) begin
                  bad++;
                  $display("FAIL %s_pixel got (%0d,%0d) fp=%h/%h want (%0d,%0d)", tag, a_h, a_v, a_hfp, a_vfp, e[9:0], e[19:10]);
               end
            end
         end
         @(negedge clk);
      end
      a_ret = 1'b0;
      total++;
      if (exp_a.size() != 0) begin
         bad++;
         $display("FAIL %s_missing_pixels got %0d left want 0", tag, exp_a.size());
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a_start = 0; a_ready = 0; a_ret = 0; a_cam_i = CAM2;
      b_start = 0; b_ready = 0; b_ret = 0; b_cam_i = CAM2;
      repeat (2) @(negedge clk);
      total++;
      if ({a_valid, a_busy, a_done, a_err, a_h, a_v, a_hfp, a_vfp, a_cam_o} !== '0) begin
         bad++;
         $display("FAIL reset_a got v=%b b=%b d=%b e=%b h=%0d v=%0d cam=%h want all 0", a_valid, a_busy, a_done, a_err, a_h, a_v, a_cam_o);
      end
      total++;
      if ({b_valid, b_busy, b_done, b_err, b_h, b_v, b_hfp, b_vfp, b_cam_o} !== '0) begin
         bad++;
         $display("FAIL reset_b got v=%b b=%b d=%b e=%b h=%0d v=%0d cam=%h want all 0", b_valid, b_busy, b_done, b_err, b_h, b_v, b_cam_o);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({a_valid, a_busy, b_valid, b_busy} !== 4'b0) begin
         bad++;
         $display("FAIL idle_after_reset got a_v=%b a_busy=%b b_v=%b b_busy=%b want 0", a_valid, a_busy, b_valid, b_busy);
      end
   endtask

   task automatic test_frame;
      int n_x, first_x, last_x, done_cnt, done_at, last_ret;
      start_a(CAM1);
      total++;
      if ({a_valid, a_busy, a_cam_o} !== {2'b11, CAM1}) begin
         bad++;
         $display("FAIL frame_start got valid=%b busy=%b cam=%h want 1 1 %h", a_valid, a_busy, a_cam_o, CAM1);
      end
      run_a("frame", 2, 30, n_x, first_x, last_x, done_cnt, done_at, last_ret);
      total++;
      if (n_x != 8 || first_x != 0 || last_x != 7) begin
         bad++;
         $display("FAIL frame_throughput got n=%0d first=%0d last=%0d want 8 0 7", n_x, first_x, last_x);
      end
      total++;
      if (done_cnt != 1 || done_at != last_ret + 1 || last_ret != 9) begin
         bad++;
         $display("FAIL frame_done got pulses=%0d at=%0d last_ret=%0d want 1 at 10 last_ret 9", done_cnt, done_at, last_ret);
      end
      total++;
      if ({a_busy, a_err} !== 2'b00) begin
         bad++;
         $display("FAIL frame_end got busy=%b err=%b want 0 0", a_busy, a_err);
      end
   endtask

   task automatic test_credit;
      int n;
      logic [19:0] e;
      load_exp(exp_b);
      b_cam_i = CAM1;
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      for (int ph = 0; ph < 2; ph++) begin
         n = 0;
         if (ph == 1) begin
            b_ret = 1'b1;
            @(negedge clk);
            b_ret = 1'b0;
         end
         for (int c = 0; c < 6; c++) begin
            b_ready = 1'b1;
            if (b_valid) begin
               n++;
               e = exp_b.pop_front();
               total++;
               if ({b_h, b_v} !== {e[9:0], e[19:10]}) begin
                  bad++;
                  $display("FAIL credit_pixel got (%0d,%0d) want (%0d,%0d)", b_h, b_v, e[9:0], e[19:10]);
               end
            end
            @(negedge clk);
         end
         total++;
         if (n != ((ph == 0) ? 2 : 1)) begin
            bad++;
            $display("FAIL credit_count_ph%0d got %0d transfers want %0d", ph, n, (ph == 0) ? 2 : 1);
         end
         total++;
         if (b_valid !== 1'b0) begin
            bad++;
            $display("FAIL credit_stop_ph%0d got valid=%b want 0", ph, b_valid);
         end
      end
   endtask

   task automatic test_ret;
      bit rdy_t[6]   = '{0, 1, 1, 0, 0, 0};
      bit ret_t[6]   = '{1, 1, 0, 1, 1, 1};
      int vld_exp[6] = '{1, 1, 0, -1, -1, -1};
      bit err_exp[6] = '{0, 0, 0, 0, 0, 1};
      logic [19:0] e;
      for (int s = 0; s < 6; s++) begin
         b_ready = rdy_t[s];
         b_ret   = ret_t[s];
         if (b_valid && b_ready) begin
            e = exp_b.pop_front();
            total++;
            if ({b_h, b_v} !== {e[9:0], e[19:10]}) begin
               bad++;
               $display("FAIL ret_pixel step%0d got (%0d,%0d) want (%0d,%0d)", s, b_h, b_v, e[9:0], e[19:10]);
            end
         end
         @(negedge clk);
         if (vld_exp[s] >= 0) begin
            total++;
            if (b_valid !== vld_exp[s][0]) begin
               bad++;
               $display("FAIL ret_valid step%0d got %b want %0d", s, b_valid, vld_exp[s]);
            end
         end
         total++;
         if (b_err !== err_exp[s]) begin
            bad++;
            $display("FAIL ret_err step%0d got %b want %b", s, b_err, err_exp[s]);
         end
      end
      b_ret = 1'b0;
      b_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (b_err !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky got %b want 1", b_err);
      end
   endtask

   task automatic test_stall;
      int n_x, first_x, last_x, done_cnt, done_at, last_ret;
      logic [19:0] e;
      start_a(CAM1);
      for (int c = 0; c < 7; c++) begin
         a_ready = (c < 2);
         a_ret   = (c == 1 || c == 2);
         if (c >= 2) begin
            total++;
            if ({a_valid, a_h, a_v, a_hfp} !== {1'b1, 10'd2, 10'd0, 32'h0002_0000}) begin
               bad++;
               $display("FAIL stall_hold c%0d got valid=%b (%0d,%0d) hfp=%h want 1 (2,0) 00020000", c, a_valid, a_h, a_v, a_hfp);
            end
         end
         if (a_valid && a_ready) begin
            e = exp_a.pop_front();
            total++;
            if ({a_h, a_v} !== {e[9:0], e[19:10]}) begin
               bad++;
               $display("FAIL stall_pre_pixel got (%0d,%0d) want (%0d,%0d)", a_h, a_v, e[9:0], e[19:10]);
            end
         end
         @(negedge clk);
      end
      a_ret = 1'b0;
      run_a("stall", 1, 40, n_x, first_x, last_x, done_cnt, done_at, last_ret);
      total++;
      if (done_cnt != 1) begin
         bad++;
         $display("FAIL stall_done got %0d pulses want 1", done_cnt);
      end
   endtask

   task automatic test_start_busy;
      int n_x, first_x, last_x, done_cnt, done_at, last_ret;
      logic [19:0] e;
      start_a(CAM1);
      for (int c = 0; c < 3; c++) begin
         a_ready = 1'b1;
         a_ret   = (c > 0);
         if (a_valid) begin
            e = exp_a.pop_front();
            total++;
            if ({a_h, a_v} !== {e[9:0], e[19:10]}) begin
               bad++;
               $display("FAIL busy_pre_pixel got (%0d,%0d) want (%0d,%0d)", a_h, a_v, e[9:0], e[19:10]);
            end
         end
         @(negedge clk);
      end
      a_start = 1'b1; a_cam_i = CAM2; a_ready = 1'b0; a_ret = 1'b1;
      @(negedge clk);
      a_start = 1'b0; a_ret = 1'b0;
      total++;
      if ({a_busy, a_valid, a_h, a_v, a_cam_o} !== {2'b11, 10'd3, 10'd0, CAM1}) begin
         bad++;
         $display("FAIL busy_restart got busy=%b valid=%b (%0d,%0d) cam=%h want 1 1 (3,0) %h", a_busy, a_valid, a_h, a_v, a_cam_o, CAM1);
      end
      run_a("busy", 1, 40, n_x, first_x, last_x, done_cnt, done_at, last_ret);
      total++;
      if (done_cnt != 1 || a_cam_o !== CAM1) begin
         bad++;
         $display("FAIL busy_end got pulses=%0d cam=%h want 1 %h", done_cnt, a_cam_o, CAM1);
      end
   endtask

   task automatic test_reset_mid;
      int n_x, first_x, last_x, done_cnt, done_at, last_ret;
      int dn;
      start_a(CAM3);
      a_ready = 1'b1;
      repeat (3) @(negedge clk);
      a_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({a_valid, a_busy, a_done, a_err, a_h, a_v, a_hfp, a_vfp, a_cam_o} !== '0) begin
         bad++;
         $display("FAIL async_reset got v=%b b=%b h=%0d v=%0d hfp=%h cam=%h want all 0", a_valid, a_busy, a_h, a_v, a_hfp, a_cam_o);
      end
      total++;
      if ({b_valid, b_busy, b_err} !== 3'b0) begin
         bad++;
         $display("FAIL async_reset_b got v=%b b=%b e=%b want 0", b_valid, b_busy, b_err);
      end
      dn = 0;
      repeat (2) begin @(negedge clk); dn += a_done; end
      rst = 1'b0;
      repeat (3) begin @(negedge clk); dn += a_done; end
      total++;
      if (dn != 0 || a_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_done got pulses=%0d busy=%b want 0 0", dn, a_busy);
      end
      start_a(CAM4);
      total++;
      if ({a_valid, a_h, a_v, a_cam_o} !== {1'b1, 10'd0, 10'd0, CAM4}) begin
         bad++;
         $display("FAIL restart got valid=%b (%0d,%0d) cam=%h want 1 (0,0) %h", a_valid, a_h, a_v, a_cam_o, CAM4);
      end
      run_a("restart", 1, 40, n_x, first_x, last_x, done_cnt, done_at, last_ret);
      total++;
      if (done_cnt != 1 || n_x != 8) begin
         bad++;
         $display("FAIL restart_frame got pulses=%0d n=%0d want 1 8", done_cnt, n_x);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_credit();
      test_ret();
      test_stall();
      test_start_busy();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
